// File: rtl/ars_sha1_pkg.sv
// Shared constants and types for the SHA-1 message feeder.
package ars_sha1_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_BYTES = 64;
    localparam int LEN_OFFSET  = 56;

    // Standard SHA-1 initial chaining value (H0..H4).
    localparam logic [159:0] SHA1_IV =
        160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    // Terminator byte appended right after the last message byte.
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_LEN,
        ST_WAIT_CORE,
        ST_LOAD,
        ST_START,
        ST_HASH
    } state_t;

    // Lowest bit of a byte lane inside a big-endian word: offset 0 -> [31:24].
    function automatic logic [4:0] byte_lane_lsb(input logic [1:0] off);
        return {~off, 3'b000};
    endfunction

endpackage

// File: rtl/ars_sha1_feeder.sv
// Collects a byte stream into 512-bit blocks, applies SHA-1 padding and the
// 64-bit bit-length, and streams each block into an external SHA-1 core.
module ars_sha1_feeder
    import ars_sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [31:0]  din,
    output logic         load,
    output logic         start,
    output logic         use_prev_cv,
    output logic [159:0] cv,
    input  logic         core_busy,
    input  logic [159:0] cv_next,
    output logic [159:0] digest,
    output logic         digest_valid
);

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_buf [BLOCK_WORDS];
    logic [6:0]    r_off;          // next free byte in the block, 0..64
    logic [60:0]   r_cnt;          // message length in bytes, wraps mod 2^61
    logic [3:0]    r_idx;          // word being loaded into the core
    logic          r_first;        // next block is the first of its message
    logic          r_msg_end;      // in_last already accepted
    logic          r_pad_done;     // 0x80 terminator already placed
    logic          r_final_blk;    // current block carries the length field
    logic          r_hash_first;   // first HASH cycle, core_busy not yet valid
    logic [159:0]  r_digest;
    logic          r_digest_valid;

    logic          w_accept;
    logic          w_take_byte;
    logic          w_full;
    logic          w_pad_write;
    logic          w_hash_done;
    logic [63:0]   w_len_field;

    assign w_accept    = in_valid && in_ready;
    assign w_take_byte = w_accept && !(in_last && in_empty);
    assign w_full      = (r_off == 7'(BLOCK_BYTES));
    assign w_pad_write = (r_state == ST_PAD) && !r_pad_done && !w_full;
    assign w_hash_done = (r_state == ST_HASH) && !r_hash_first && !core_busy;
    assign w_len_field = {r_cnt, 3'b000};

    assign cv           = SHA1_IV;
    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first keeps this purely combinational (no latch).
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_accept) begin
                    if (in_last)                        w_next = ST_PAD;
                    else if (r_off == 7'(BLOCK_BYTES - 1)) w_next = ST_WAIT_CORE;
                    else                                w_next = ST_FILL;
                end
            end
            ST_PAD: begin
                // Terminator fits before the length field -> finish this block;
                // otherwise hash it and build a length-only block afterwards.
                if (r_pad_done)                    w_next = ST_LEN;
                else if (w_full)                   w_next = ST_WAIT_CORE;
                else if (r_off < 7'(LEN_OFFSET))   w_next = ST_LEN;
                else                               w_next = ST_WAIT_CORE;
            end
            ST_LEN:       w_next = ST_WAIT_CORE;
            ST_WAIT_CORE: if (!core_busy) w_next = ST_LOAD;
            ST_LOAD:      if (r_idx == 4'(BLOCK_WORDS - 1)) w_next = ST_START;
            ST_START:     w_next = ST_HASH;
            ST_HASH: begin
                if (w_hash_done) begin
                    if (r_final_blk)    w_next = ST_IDLE;
                    else if (r_msg_end) w_next = ST_PAD;
                    else                w_next = ST_FILL;
                end
            end
            default:      w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        in_ready    = ((r_state == ST_IDLE) || (r_state == ST_FILL)) && !w_full;
        load        = (r_state == ST_LOAD);
        start       = (r_state == ST_START);
        use_prev_cv = (r_state == ST_START) && !r_first;
        din         = (r_state == ST_LOAD) ? r_buf[r_idx] : 32'h0;
    end

    // Block buffer, counters and message bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the buffer is reset because padding relies on unwritten bytes being zero.
            for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
            r_off          <= '0;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_first        <= 1'b1;
            r_msg_end      <= 1'b0;
            r_pad_done     <= 1'b0;
            r_final_blk    <= 1'b0;
            r_hash_first   <= 1'b0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            r_hash_first   <= (r_state == ST_START);

            if (w_take_byte) begin
                r_buf[r_off[5:2]][byte_lane_lsb(r_off[1:0]) +: 8] <= in_data;
                r_off <= r_off + 7'd1;
                r_cnt <= r_cnt + 61'd1;
            end
            if (w_accept && in_last) r_msg_end <= 1'b1;

            if (w_pad_write) begin
                r_buf[r_off[5:2]][byte_lane_lsb(r_off[1:0]) +: 8] <= PAD_BYTE;
                r_off      <= r_off + 7'd1;
                r_pad_done <= 1'b1;
            end

            if (r_state == ST_LEN) begin
                r_buf[BLOCK_WORDS - 2] <= w_len_field[63:32];
                r_buf[BLOCK_WORDS - 1] <= w_len_field[31:0];
                r_final_blk            <= 1'b1;
            end

            if (r_state == ST_LOAD)  r_idx   <= r_idx + 4'd1;
            if (r_state == ST_START) r_first <= 1'b0;

            if (w_hash_done) begin
                for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
                r_off <= '0;
                if (r_final_blk) begin
                    r_digest       <= cv_next;
                    r_digest_valid <= 1'b1;
                    r_cnt          <= '0;
                    r_first        <= 1'b1;
                    r_msg_end      <= 1'b0;
                    r_pad_done     <= 1'b0;
                    r_final_blk    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ars_sha1_feeder.sv
// Self-checking bench for ars_sha1_feeder with a behavioural SHA-1 core.
module tb_ars_sha1_feeder;

    typedef logic [7:0] byte_q_t [$];

    localparam logic [159:0] IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_last, in_empty;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [31:0]  din;
    logic         load, start, use_prev_cv;
    logic [159:0] cv, cv_next, digest;
    logic         core_busy, digest_valid;

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_blk_q [$];
    logic         exp_prev_q [$];
    logic [159:0] exp_dig_q [$];

    logic         force_busy = 1'b0;
    logic         ready_watch = 1'b0;
    int           ready_viol = 0;

    always #5 clk = ~clk;

    ars_sha1_feeder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
        .in_ready(in_ready),
        .din(din), .load(load), .start(start), .use_prev_cv(use_prev_cv), .cv(cv),
        .core_busy(core_busy), .cv_next(cv_next),
        .digest(digest), .digest_valid(digest_valid)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Behavioural SHA-1 core: captures 16 words, raises busy one cycle after start.
    logic [511:0] m_blk;
    logic [159:0] m_cv, m_result, m_cv_next;
    int           m_idx, m_cnt;
    logic         m_pend, m_busy;

    assign core_busy = m_busy | force_busy;
    assign cv_next   = m_cv_next;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_idx <= 0; m_cnt <= 0; m_pend <= 1'b0; m_busy <= 1'b0;
            m_blk <= '0; m_cv <= '0; m_result <= '0; m_cv_next <= '0;
        end else begin
            m_pend <= 1'b0;
            if (load && m_idx < 16) begin
                m_blk[511 - 32*m_idx -: 32] <= din;
                m_idx <= m_idx + 1;
            end
            if (start) begin
                m_result <= sha1_compress(use_prev_cv ? m_cv : cv, m_blk);
                m_pend   <= 1'b1;
                m_idx    <= 0;
            end
            if (m_pend) begin
                m_busy <= 1'b1;
                m_cnt  <= 20;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy    <= 1'b0;
                    m_cv_next <= m_result;
                    m_cv      <= m_result;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Monitor: assembles load bursts and compares against the scoreboard.
    initial begin
        int           load_cnt;
        logic [511:0] got_blk;
        load_cnt = 0;
        got_blk  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                load_cnt = 0;
                continue;
            end
            if (ready_watch && in_ready) ready_viol++;
            if (load) begin
                if (load_cnt < 16) got_blk[511 - 32*load_cnt -: 32] = din;
                load_cnt++;
            end else if (start) begin
                check("start_after_16_loads", 512'(load_cnt), 512'(16));
                if (exp_blk_q.size() == 0) begin
                    fail("unexpected_block");
                end else begin
                    check("block_words", got_blk, exp_blk_q.pop_front());
                    check("use_prev_cv", 512'(use_prev_cv), 512'(exp_prev_q.pop_front()));
                end
                ready_watch = 1'b0;
                load_cnt    = 0;
            end else if (load_cnt != 0) begin
                fail("load_burst_not_followed_by_start");
                load_cnt = 0;
            end
            if (digest_valid) begin
                if (exp_dig_q.size() == 0) fail("unexpected_digest_valid");
                else check("digest", 512'(digest), 512'(exp_dig_q.pop_front()));
            end
        end
    end

    // Pushes the padded blocks of a message and returns the reference digest.
    task automatic expect_msg(input byte_q_t msg, output logic [159:0] model_dig);
        byte_q_t      p;
        logic [63:0]  bits;
        logic [511:0] blk;
        logic [159:0] h;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) << 3;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        h = IV;
        blk = '0;
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
            exp_blk_q.push_back(blk);
            exp_prev_q.push_back(b != 0);
            h = sha1_compress(h, blk);
        end
        model_dig = h;
    endtask

    task automatic send_beat(input logic [7:0] data, input logic last, input logic empty);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = data; in_last = last; in_empty = empty;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail("in_ready_timeout");
        @(posedge clk);
    endtask

    task automatic drive_msg(input byte_q_t msg);
        if (msg.size() == 0) begin
            send_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < msg.size(); i++) begin
                send_beat(msg[i], i == msg.size() - 1, 1'b0);
                if (i == 63) ready_watch = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    endtask

    task automatic wait_digest();
        int n;
        n = 0;
        while (exp_dig_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_dig_q.size() != 0) begin
            fail("digest_timeout");
            exp_dig_q.delete(); exp_blk_q.delete(); exp_prev_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic send_msg(input byte_q_t msg, input logic [159:0] dig, input bit known);
        logic [159:0] md;
        expect_msg(msg, md);
        exp_dig_q.push_back(known ? dig : md);
        ready_viol = 0;
        drive_msg(msg);
        wait_digest();
        if (msg.size() >= 64) check("in_ready_low_while_full", 512'(ready_viol), 512'(0));
        ready_watch = 1'b0;
    endtask

    task automatic str_q(input string s, output byte_q_t q);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic rep_q(input int n, output byte_q_t q);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'h61);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t      q;
        logic [159:0] md;
        int           n, cnt, busy_loads;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",     512'(in_ready),     512'(1));
        check("rst_load",         512'(load),         512'(0));
        check("rst_start",        512'(start),        512'(0));
        check("rst_use_prev_cv",  512'(use_prev_cv),  512'(0));
        check("rst_din",          512'(din),          512'(0));
        check("rst_digest",       512'(digest),       512'(0));
        check("rst_digest_valid", 512'(digest_valid), 512'(0));
        check("cv_constant",      512'(cv),           512'(IV));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        str_q("abc", q);
        send_msg(q, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b1);
        str_q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", q);
        send_msg(q, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 1'b1);
        q = {};
        send_msg(q, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709, 1'b1);
        rep_q(55, q);
        send_msg(q, '0, 1'b0);
        rep_q(64, q);
        send_msg(q, '0, 1'b0);
        rep_q(100, q);
        send_msg(q, '0, 1'b0);

        // Core held busy for 100 cycles before the burst.
        str_q("abc", q);
        expect_msg(q, md);
        exp_dig_q.push_back(160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        force_busy = 1'b1;
        drive_msg(q);
        busy_loads = 0;
        repeat (100) begin
            @(negedge clk);
            if (load) busy_loads++;
        end
        check("no_load_while_busy", 512'(busy_loads), 512'(0));
        force_busy = 1'b0;
        wait_digest();

        // Reset during the 8th load cycle of an "abc" block.
        str_q("abc", q);
        drive_msg(q);
        n = 0; cnt = 0;
        while (cnt < 8 && n < 1000) begin
            @(negedge clk);
            n++;
            if (load) cnt++;
        end
        if (cnt < 8) fail("reset_test_load_timeout");
        #1 reset = 1'b1;
        #1;
        check("mid_rst_load",         512'(load),         512'(0));
        check("mid_rst_start",        512'(start),        512'(0));
        check("mid_rst_digest_valid", 512'(digest_valid), 512'(0));
        check("mid_rst_digest",       512'(digest),       512'(0));
        check("mid_rst_in_ready",     512'(in_ready),     512'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        str_q("abc", q);
        send_msg(q, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b1);

        check("blocks_drained", 512'(exp_blk_q.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
